// File: rtl/light_phased.sv
// ============================================================================
// Module   : light_phased
// Purpose  : Four-way intersection light, rotating green N->E->S->W with an
//            all-Stop clearance interval between phases.
//            Define LIGHT_ACTUATED_EN for sensor-actuated skip/rest/early-end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module light_phased #(
  parameter int GREEN_CYCLES = 64,
  parameter int MIN_GREEN    = 16,
  parameter int CLEAR_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sensor_light,
  input  logic [29:0] general_sensors,
  output logic [2:0]  outN,
  output logic [2:0]  outS,
  output logic [2:0]  outE,
  output logic [2:0]  outW,
  output logic [29:0] debug_port
);

  localparam logic [2:0]       c_go         = 3'b100;
  localparam logic [2:0]       c_stop       = 3'b000;
  localparam logic [CNT_W-1:0] c_green_last = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_clear_last = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_GREEN = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t           r_state;
  logic [1:0]       r_dir;
  logic [CNT_W-1:0] r_timer;
  logic [3:0]       r_req;
  logic [2:0]       r_outN, r_outS, r_outE, r_outW;

  logic             w_green_end;
  logic [1:0]       w_next_dir;
  logic [3:0]       w_req_nxt;
  logic [21:0]      w_timer_ext;

`ifdef LIGHT_ACTUATED_EN
  localparam logic [CNT_W-1:0] c_min_last = CNT_W'(MIN_GREEN - 1);

  // Sensors re-ordered to direction index {W,S,E,N}.
  logic [3:0] w_sens;
  logic [3:0] w_others;
  logic [1:0] w_cand;
  logic       w_unused;

  assign w_sens   = {sensor_light[7], sensor_light[4], sensor_light[5], sensor_light[6]};
  assign w_unused = ^{general_sensors, sensor_light[3:0]};

  always_comb begin
    w_others    = r_req & ~(4'b0001 << r_dir);
    w_green_end = (|w_others) &&
                  (((r_timer >= c_min_last) && !w_sens[r_dir]) || (r_timer == c_green_last));

    // Scan downward so the nearest pending approach is the last one written.
    w_next_dir = r_dir;
    w_cand     = r_dir;
    for (int k = 3; k >= 1; k--) begin
      w_cand = r_dir + 2'(k);
      if (r_req[w_cand]) begin
        w_next_dir = w_cand;
      end
    end

    w_req_nxt = r_req | w_sens;
    if (r_state == ST_GREEN) begin
      w_req_nxt[r_dir] = 1'b0;
    end
    if ((r_state == ST_CLEAR) && (r_timer == c_clear_last)) begin
      w_req_nxt[w_next_dir] = 1'b0;
    end
  end
`else
  localparam int c_unused_min = MIN_GREEN;
  logic w_unused;

  assign w_unused = ^{general_sensors, sensor_light};

  always_comb begin
    w_green_end = (r_timer == c_green_last);
    w_next_dir  = r_dir + 2'd1;
    w_req_nxt   = 4'b0000;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_GREEN;
      r_dir   <= 2'd0;
      r_timer <= '0;
      r_req   <= 4'b0000;
      r_outN  <= c_go;
      r_outS  <= c_stop;
      r_outE  <= c_stop;
      r_outW  <= c_stop;
    end else begin
      r_req <= w_req_nxt;
      case (r_state)
        ST_GREEN: begin
          if (w_green_end) begin
            r_state <= ST_CLEAR;
            r_timer <= '0;
            r_outN  <= c_stop;
            r_outS  <= c_stop;
            r_outE  <= c_stop;
            r_outW  <= c_stop;
          end else if (r_timer != c_green_last) begin
            // Saturating at the last count is what lets an idle green rest.
            r_timer <= r_timer + c_one;
          end
        end
        ST_CLEAR: begin
          if (r_timer == c_clear_last) begin
            r_state <= ST_GREEN;
            r_dir   <= w_next_dir;
            r_timer <= '0;
            r_outN  <= (w_next_dir == 2'd0) ? c_go : c_stop;
            r_outE  <= (w_next_dir == 2'd1) ? c_go : c_stop;
            r_outS  <= (w_next_dir == 2'd2) ? c_go : c_stop;
            r_outW  <= (w_next_dir == 2'd3) ? c_go : c_stop;
          end else begin
            r_timer <= r_timer + c_one;
          end
        end
        default: begin
          r_state <= ST_GREEN;
        end
      endcase
    end
  end

  assign w_timer_ext = 22'(r_timer);
  assign outN        = r_outN;
  assign outS        = r_outS;
  assign outE        = r_outE;
  assign outW        = r_outW;
  assign debug_port  = {r_dir, (r_state == ST_CLEAR), r_req, 1'b0, w_timer_ext};

endmodule

`default_nettype wire

// File: tb/tb_light_phased.sv
// ============================================================================
// Module   : tb_light_phased
// Purpose  : Self-checking bench for light_phased (fixed or actuated build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_light_phased;

  localparam int G  = 8;
  localparam int C  = 2;
  localparam int MG = 3;
  localparam int CW = 8;
  localparam logic [2:0] GO   = 3'b100;
  localparam logic [2:0] STOP = 3'b000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sensor_light = 8'h00;
  logic [29:0] general_sensors = 30'h0;
  logic [2:0]  outN, outS, outE, outW;
  logic [29:0] debug_port;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int       m_t;
  int       m_dir;
  int       m_elapsed;
  bit       m_green;
  bit [3:0] m_wait;

  light_phased #(
    .GREEN_CYCLES(G),
    .MIN_GREEN   (MG),
    .CLEAR_CYCLES(C),
    .CNT_W       (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sensor_light   (sensor_light),
    .general_sensors(general_sensors),
    .outN           (outN),
    .outS           (outS),
    .outE           (outE),
    .outW           (outW),
    .debug_port     (debug_port)
  );

  always #5 clk = ~clk;

  function automatic int sidx(input int d);
    case (d)
      0:       return 6;
      1:       return 5;
      2:       return 4;
      default: return 7;
    endcase
  endfunction

  task automatic model_reset();
    m_t       = 0;
    m_dir     = 0;
    m_green   = 1'b1;
    m_elapsed = 0;
    m_wait    = 4'b0000;
  endtask

  // Advance the model over one clock edge given the sensors seen in that cycle.
  task automatic model_step(input logic [7:0] s);
`ifdef LIGHT_ACTUATED_EN
    bit [3:0] nw;
    bit       other;
    int       nd;
    other = 1'b0;
    for (int x = 0; x < 4; x++) if (x != m_dir && m_wait[x]) other = 1'b1;
    nw = m_wait;
    for (int x = 0; x < 4; x++) if (s[sidx(x)]) nw[x] = 1'b1;
    if (m_green) begin
      nw[m_dir] = 1'b0;
      if (other && ((m_elapsed >= MG - 1 && !s[sidx(m_dir)]) || m_elapsed >= G - 1)) begin
        m_green   = 1'b0;
        m_elapsed = 0;
      end else begin
        m_elapsed++;
      end
    end else if (m_elapsed == C - 1) begin
      nd = m_dir;
      for (int k = 3; k >= 1; k--) if (m_wait[(m_dir + k) % 4]) nd = (m_dir + k) % 4;
      m_dir     = nd;
      m_green   = 1'b1;
      m_elapsed = 0;
      nw[nd]    = 1'b0;
    end else begin
      m_elapsed++;
    end
    m_wait = nw;
    m_t++;
`else
    int ph;
    m_t++;
    ph        = m_t % (4 * (G + C));
    m_dir     = ph / (G + C);
    m_elapsed = ph % (G + C);
    m_green   = (m_elapsed < G);
    if (!m_green) m_elapsed -= G;
    if (s == 8'hFF) m_wait = 4'b0000;
`endif
  endtask

  // Expected {outN,outE,outS,outW,debug_port}
  function automatic logic [41:0] model_expect();
    logic [2:0]  o [4];
    int          tmr;
    logic [29:0] dbg;
    for (int d = 0; d < 4; d++) o[d] = (m_green && m_dir == d) ? GO : STOP;
    tmr = (m_green && m_elapsed > G - 1) ? G - 1 : m_elapsed;
    dbg = {2'(m_dir), ~m_green, m_wait, 1'b0, 22'(tmr)};
    return {o[0], o[1], o[2], o[3], dbg};
  endfunction

  task automatic cycle(input logic [7:0] s);
    sensor_light    = s;
    general_sensors = 30'($urandom);
    model_step(s);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [41:0] exp_v;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    exp_v = model_expect();
    checks++;
    if ({outN, outE, outS, outW, debug_port} !== exp_v) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", {outN, outE, outS, outW, debug_port}, exp_v);
    end
    checks++;
    if (outN !== GO || debug_port !== 30'h0) begin
      errors++;
      $display("FAIL reset_outn: outN=%b debug=%h expected outN=100 debug=0", outN, debug_port);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [41:0] exp_v;
    int          len;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      len = (it == 0) ? 13 : int'($urandom_range(5, 45));
      for (int i = 0; i < len; i++) cycle(8'($urandom));
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      exp_v = model_expect();
      checks++;
      if ({outN, outE, outS, outW, debug_port} !== exp_v) begin
        errors++;
        $display("FAIL async_reset it=%0d: got %h expected %h", it,
                 {outN, outE, outS, outW, debug_port}, exp_v);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < G + 4; i++) begin
        exp_v = model_expect();
        checks++;
        if ({outN, outE, outS, outW, debug_port} !== exp_v) begin
          errors++;
          $display("FAIL after_reset it=%0d cyc=%0d: got %h expected %h", it, i,
                   {outN, outE, outS, outW, debug_port}, exp_v);
        end
        cycle(8'h00);
      end
    end
  endtask

`ifndef LIGHT_ACTUATED_EN
  task automatic test_fixed_rotation();
    logic [41:0] exp_v;
    do_reset();
    for (int t = 0; t <= 2 * 4 * (G + C) + 3; t++) begin
      exp_v = model_expect();
      checks++;
      if ({outN, outE, outS, outW, debug_port} !== exp_v) begin
        errors++;
        $display("FAIL fixed_rotation t=%0d: got %h expected %h", t,
                 {outN, outE, outS, outW, debug_port}, exp_v);
      end
      if (t == 10 || t == 40) begin
        checks++;
        if ((t == 10 && outE !== GO) || (t == 40 && outN !== GO)) begin
          errors++;
          $display("FAIL fixed_milestone t=%0d: outN=%b outE=%b expected Go", t, outN, outE);
        end
      end
      cycle(8'($urandom));
    end
  endtask
`else
  task automatic run_checked(input string name, input int n, input logic [7:0] s);
    logic [41:0] exp_v;
    for (int i = 0; i < n; i++) begin
      exp_v = model_expect();
      checks++;
      if ({outN, outE, outS, outW, debug_port} !== exp_v) begin
        errors++;
        $display("FAIL %s cyc=%0d: got %h expected %h", name, i,
                 {outN, outE, outS, outW, debug_port}, exp_v);
      end
      cycle(s);
    end
  endtask

  task automatic test_act_skip();
    do_reset();
    run_checked("act_skip", 10, 8'h80);
    checks++;
    if (outW !== GO || outE !== STOP || outS !== STOP) begin
      errors++;
      $display("FAIL act_skip_west: outW=%b outE=%b outS=%b expected W Go", outW, outE, outS);
    end
    run_checked("act_skip_tail", 6, 8'h80);
  endtask

  task automatic test_act_rest();
    do_reset();
    run_checked("act_rest", 30, 8'h00);
    checks++;
    if (outN !== GO || debug_port[21:0] !== 22'd7) begin
      errors++;
      $display("FAIL act_rest_sat: outN=%b timer=%0d expected Go,7", outN, debug_port[21:0]);
    end
    run_checked("act_rest_pulse", 1, 8'h20);
    run_checked("act_rest_after", 3, 8'h00);
    checks++;
    if (outE !== GO) begin
      errors++;
      $display("FAIL act_rest_east: outE=%b expected 100", outE);
    end
  endtask

  task automatic test_act_min();
    do_reset();
    run_checked("act_min_pulse", 1, 8'h10);
    run_checked("act_min", 2, 8'h00);
    checks++;
    if (debug_port[27] !== 1'b1 || outN !== STOP) begin
      errors++;
      $display("FAIL act_min_clear: clear=%b outN=%b expected 1,000", debug_port[27], outN);
    end
    run_checked("act_min_clr", 2, 8'h00);
    checks++;
    if (outS !== GO) begin
      errors++;
      $display("FAIL act_min_south: outS=%b expected 100", outS);
    end
  endtask

  task automatic test_act_hold_n();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(8'h40);
      checks++;
      if (debug_port[23] !== 1'b0) begin
        errors++;
        $display("FAIL act_hold_n cyc=%0d: latchN=%b expected 0", i, debug_port[23]);
      end
    end
  endtask

  task automatic test_act_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      run_checked("act_random", 1, ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef LIGHT_ACTUATED_EN
    test_fixed_rotation();
`else
    test_act_skip();
    test_act_rest();
    test_act_min();
    test_act_hold_n();
    test_act_random();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
